// File: rtl/pseudo_color_mp.sv
// Pseudo-colour mapper: turns gray+detail pixels into YUV through a palette RAM.
// The palette and bypass mode switch only at a frame boundary (vsync rising edge),
// so a frame is never rendered with a mix of palettes.
module pseudo_color_mp #(
    parameter int PIXEL_DATA_W = 8,
    parameter int DETAIL_LUT_W = 3,
    parameter int Y_DATA_W     = 8,
    parameter int U_DATA_W     = 8,
    parameter int V_DATA_W     = 8,
    parameter int PAL_SEL_W    = 2,
    parameter int DATA_LUT_W   = PIXEL_DATA_W + DETAIL_LUT_W,
    parameter int YUV_DATA_W   = Y_DATA_W + U_DATA_W + V_DATA_W
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            vsync_i,
    input  logic                            data_valid_i,
    input  logic [DATA_LUT_W-1:0]           data_lut_i,
    input  logic [PAL_SEL_W-1:0]            palette_sel_i,
    input  logic                            bypass_i,
    input  logic                            cfg_we_i,
    input  logic [PAL_SEL_W+DATA_LUT_W-1:0] cfg_addr_i,
    input  logic [YUV_DATA_W-1:0]           cfg_data_i,
    output logic                            data_valid_o,
    output logic [Y_DATA_W-1:0]             y_data_o,
    output logic [U_DATA_W-1:0]             u_data_o,
    output logic [V_DATA_W-1:0]             v_data_o,
    output logic [PAL_SEL_W-1:0]            palette_act_o,
    output logic                            cfg_collision_o
);

    localparam int ADDR_W    = PAL_SEL_W + DATA_LUT_W;
    localparam int RAM_DEPTH = 1 << ADDR_W;

    logic [YUV_DATA_W-1:0]   pal_ram [0:RAM_DEPTH-1];
    logic [YUV_DATA_W-1:0]   ram_q;

    logic                    vsync_d;
    logic                    vsync_rise;
    logic [PAL_SEL_W-1:0]    pal_act;
    logic                    byp_act;
    logic                    collision;

    logic                    s1_valid;
    logic                    s1_byp;
    logic [PIXEL_DATA_W-1:0] s1_gray;

    assign vsync_rise      = vsync_i & ~vsync_d;
    assign palette_act_o   = pal_act;
    assign cfg_collision_o = collision;

    // Palette RAM write port; writes while reset is held are dropped, contents are never cleared
    always_ff @(posedge clk_i) begin
        if (cfg_we_i && rst_i) begin
            pal_ram[cfg_addr_i] <= cfg_data_i;
        end
    end

    // Palette RAM read port; read-before-write so a same-address write is seen one read later
    always_ff @(posedge clk_i) begin
        if (data_valid_i) begin
            ram_q <= pal_ram[{pal_act, data_lut_i}];
        end
    end

    // Frame-boundary shadow registers and sticky collision flag (a new collision beats the clear)
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vsync_d   <= 1'b1;
            pal_act   <= '0;
            byp_act   <= 1'b0;
            collision <= 1'b0;
        end else begin
            vsync_d <= vsync_i;
            if (vsync_rise) begin
                pal_act <= palette_sel_i;
                byp_act <= bypass_i;
            end
            if (cfg_we_i && data_valid_i && (cfg_addr_i[ADDR_W-1 -: PAL_SEL_W] == pal_act)) begin
                collision <= 1'b1;
            end else if (vsync_rise) begin
                collision <= 1'b0;
            end
        end
    end

    // Stage 1: capture valid, mode and gray value alongside the RAM read
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_valid <= 1'b0;
            s1_byp   <= 1'b0;
            s1_gray  <= '0;
        end else begin
            s1_valid <= data_valid_i;
            if (data_valid_i) begin
                s1_byp  <= byp_act;
                s1_gray <= data_lut_i[DATA_LUT_W-1 -: PIXEL_DATA_W];
            end
        end
    end

    // Stage 2: build the output pixel from either the palette word or the gray value
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_valid_o <= 1'b0;
            y_data_o     <= '0;
            u_data_o     <= '0;
            v_data_o     <= '0;
        end else begin
            data_valid_o <= s1_valid;
            if (s1_valid) begin
                if (s1_byp) begin
                    y_data_o <= Y_DATA_W'(s1_gray) << (Y_DATA_W - PIXEL_DATA_W);
                    u_data_o <= U_DATA_W'(1) << (U_DATA_W - 1);
                    v_data_o <= V_DATA_W'(1) << (V_DATA_W - 1);
                end else begin
                    y_data_o <= ram_q[YUV_DATA_W-1 -: Y_DATA_W];
                    u_data_o <= ram_q[V_DATA_W +: U_DATA_W];
                    v_data_o <= ram_q[V_DATA_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_pseudo_color_mp.sv
// Directed testbench for pseudo_color_mp: palette lookup, frame-boundary switching,
// bypass, read-first collisions and reset behaviour.
module tb_pseudo_color_mp;

    localparam int DATA_LUT_W = 11;
    localparam int PAL_SEL_W  = 2;
    localparam int ADDR_W     = 13;
    localparam int YUV_W      = 24;

    logic                  clk_i;
    logic                  rst_i;
    logic                  vsync_i;
    logic                  data_valid_i;
    logic [DATA_LUT_W-1:0] data_lut_i;
    logic [PAL_SEL_W-1:0]  palette_sel_i;
    logic                  bypass_i;
    logic                  cfg_we_i;
    logic [ADDR_W-1:0]     cfg_addr_i;
    logic [YUV_W-1:0]      cfg_data_i;
    logic                  data_valid_o;
    logic [7:0]            y_data_o;
    logic [7:0]            u_data_o;
    logic [7:0]            v_data_o;
    logic [PAL_SEL_W-1:0]  palette_act_o;
    logic                  cfg_collision_o;

    int total_checks;
    int bad_checks;

    pseudo_color_mp dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .vsync_i        (vsync_i),
        .data_valid_i   (data_valid_i),
        .data_lut_i     (data_lut_i),
        .palette_sel_i  (palette_sel_i),
        .bypass_i       (bypass_i),
        .cfg_we_i       (cfg_we_i),
        .cfg_addr_i     (cfg_addr_i),
        .cfg_data_i     (cfg_data_i),
        .data_valid_o   (data_valid_o),
        .y_data_o       (y_data_o),
        .u_data_o       (u_data_o),
        .v_data_o       (v_data_o),
        .palette_act_o  (palette_act_o),
        .cfg_collision_o(cfg_collision_o)
    );

    // Free-running 100 MHz clock
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic stepClk();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cfgWrite(input logic [ADDR_W-1:0] addr, input logic [YUV_W-1:0] data);
        cfg_we_i   = 1'b1;
        cfg_addr_i = addr;
        cfg_data_i = data;
        stepClk();
        cfg_we_i   = 1'b0;
    endtask

    task automatic vsyncEdge(input logic [PAL_SEL_W-1:0] pal, input logic byp);
        palette_sel_i = pal;
        bypass_i      = byp;
        vsync_i       = 1'b1;
        stepClk();
        vsync_i       = 1'b0;
        stepClk();
    endtask

    // Push one pixel and check the 2-cycle latency and the resulting YUV value
    task automatic applyStimulus(input string tag, input logic [DATA_LUT_W-1:0] idx,
                                 input logic [7:0] ey, input logic [7:0] eu, input logic [7:0] ev);
        data_valid_i = 1'b1;
        data_lut_i   = idx;
        stepClk();
        data_valid_i = 1'b0;
        checkOutput({tag, "_lat1"}, data_valid_o, 0);
        stepClk();
        checkOutput({tag, "_valid"}, data_valid_o, 1);
        checkOutput({tag, "_y"}, y_data_o, ey);
        checkOutput({tag, "_u"}, u_data_o, eu);
        checkOutput({tag, "_v"}, v_data_o, ev);
    endtask

    initial begin
        total_checks  = 0;
        bad_checks    = 0;
        rst_i         = 1'b0;
        vsync_i       = 1'b0;
        data_valid_i  = 1'b0;
        data_lut_i    = '0;
        palette_sel_i = '0;
        bypass_i      = 1'b0;
        cfg_we_i      = 1'b0;
        cfg_addr_i    = '0;
        cfg_data_i    = '0;

        // Reset state, including a pixel offered while in reset
        stepClk();
        data_valid_i = 1'b1;
        stepClk();
        stepClk();
        data_valid_i = 1'b0;
        checkOutput("rst_valid", data_valid_o, 0);
        checkOutput("rst_y", y_data_o, 0);
        checkOutput("rst_u", u_data_o, 0);
        checkOutput("rst_v", v_data_o, 0);
        checkOutput("rst_pal", palette_act_o, 0);
        checkOutput("rst_coll", cfg_collision_o, 0);
        rst_i = 1'b1;
        stepClk();
        stepClk();
        checkOutput("rel_valid", data_valid_o, 0);

        // Basic palette lookup after switching to palette 1
        cfgWrite({2'd1, 11'h155}, 24'h8040C0);
        vsyncEdge(2'd1, 1'b0);
        checkOutput("sw1_pal", palette_act_o, 1);
        applyStimulus("pal1", 11'h155, 8'h80, 8'h40, 8'hC0);

        // Palette request changes mid-frame without vsync: no effect
        cfgWrite({2'd2, 11'h155}, 24'h224466);
        palette_sel_i = 2'd2;
        stepClk();
        stepClk();
        checkOutput("midframe_pal", palette_act_o, 1);
        applyStimulus("midframe", 11'h155, 8'h80, 8'h40, 8'hC0);

        // Pixel on the vsync edge cycle uses the old palette, the next one the new palette
        vsync_i      = 1'b1;
        data_valid_i = 1'b1;
        data_lut_i   = 11'h155;
        stepClk();
        vsync_i      = 1'b0;
        stepClk();
        data_valid_i = 1'b0;
        checkOutput("edge_old_valid", data_valid_o, 1);
        checkOutput("edge_old_y", y_data_o, 8'h80);
        checkOutput("edge_old_v", v_data_o, 8'hC0);
        stepClk();
        checkOutput("edge_new_valid", data_valid_o, 1);
        checkOutput("edge_new_y", y_data_o, 8'h22);
        checkOutput("edge_new_u", u_data_o, 8'h44);
        checkOutput("edge_new_v", v_data_o, 8'h66);
        checkOutput("edge_new_pal", palette_act_o, 2);

        // Grayscale bypass
        vsyncEdge(2'd2, 1'b1);
        applyStimulus("byp_ff", 11'h7F8, 8'hFF, 8'h80, 8'h80);
        applyStimulus("byp_54", 11'h2A5, 8'h54, 8'h80, 8'h80);

        // Back to palette 0 for collision tests
        vsyncEdge(2'd0, 1'b0);
        cfgWrite({2'd0, 11'h010}, 24'hAABBCC);
        checkOutput("nocoll_idle", cfg_collision_o, 0);
        cfg_we_i     = 1'b1;
        cfg_addr_i   = {2'd3, 11'h010};
        cfg_data_i   = 24'h777777;
        data_valid_i = 1'b1;
        data_lut_i   = 11'h010;
        stepClk();
        cfg_we_i     = 1'b0;
        data_valid_i = 1'b0;
        checkOutput("nocoll_otherpal", cfg_collision_o, 0);
        stepClk();
        stepClk();

        // Same-address write and read on the active palette: read-first plus collision
        cfg_we_i     = 1'b1;
        cfg_addr_i   = {2'd0, 11'h010};
        cfg_data_i   = 24'h112233;
        data_valid_i = 1'b1;
        data_lut_i   = 11'h010;
        stepClk();
        cfg_we_i     = 1'b0;
        data_valid_i = 1'b0;
        checkOutput("coll_set", cfg_collision_o, 1);
        stepClk();
        checkOutput("rf_valid", data_valid_o, 1);
        checkOutput("rf_y", y_data_o, 8'hAA);
        checkOutput("rf_u", u_data_o, 8'hBB);
        checkOutput("rf_v", v_data_o, 8'hCC);
        applyStimulus("rf_next", 11'h010, 8'h11, 8'h22, 8'h33);
        checkOutput("coll_sticky", cfg_collision_o, 1);
        vsyncEdge(2'd0, 1'b0);
        checkOutput("coll_clear", cfg_collision_o, 0);

        // Collision on the vsync edge cycle: set wins over clear
        vsync_i      = 1'b1;
        cfg_we_i     = 1'b1;
        cfg_addr_i   = {2'd0, 11'h020};
        cfg_data_i   = 24'h000000;
        data_valid_i = 1'b1;
        data_lut_i   = 11'h020;
        stepClk();
        vsync_i      = 1'b0;
        cfg_we_i     = 1'b0;
        data_valid_i = 1'b0;
        checkOutput("coll_setwins", cfg_collision_o, 1);
        stepClk();
        vsyncEdge(2'd0, 1'b0);
        checkOutput("coll_clear2", cfg_collision_o, 0);

        // Continuous stream with a reset pulse in the middle
        cfgWrite({2'd0, 11'h030}, 24'h0F1E2D);
        data_valid_i = 1'b1;
        data_lut_i   = 11'h030;
        for (int c = 0; c < 16; c++) begin
            if (c == 5) begin
                rst_i = 1'b0;
                #1;
                checkOutput("midrst_valid", data_valid_o, 0);
                checkOutput("midrst_y", y_data_o, 0);
                checkOutput("midrst_u", u_data_o, 0);
            end
            if (c == 6) begin
                rst_i = 1'b1;
            end
            stepClk();
            if (c == 3) begin
                checkOutput("stream_valid", data_valid_o, 1);
                checkOutput("stream_y", y_data_o, 8'h0F);
            end
            if (c == 6) begin
                checkOutput("postrst_lat1", data_valid_o, 0);
            end
            if (c == 7) begin
                checkOutput("postrst_valid", data_valid_o, 1);
                checkOutput("postrst_y", y_data_o, 8'h0F);
                checkOutput("postrst_v", v_data_o, 8'h2D);
            end
        end
        data_valid_i = 1'b0;
        stepClk();
        stepClk();

        // Writes during reset are dropped and RAM contents survive reset
        rst_i = 1'b0;
        stepClk();
        cfgWrite({2'd0, 11'h030}, 24'h999999);
        rst_i = 1'b1;
        stepClk();
        applyStimulus("rstwr", 11'h030, 8'h0F, 8'h1E, 8'h2D);

        // vsync already high at reset release causes no switch
        rst_i         = 1'b0;
        vsync_i       = 1'b1;
        palette_sel_i = 2'd3;
        stepClk();
        rst_i = 1'b1;
        stepClk();
        stepClk();
        stepClk();
        checkOutput("vs_high_pal", palette_act_o, 0);
        vsync_i = 1'b0;
        stepClk();
        checkOutput("vs_low_pal", palette_act_o, 0);
        vsync_i = 1'b1;
        stepClk();
        checkOutput("vs_rise_pal", palette_act_o, 3);
        vsync_i = 1'b0;
        stepClk();

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/pseudo_color_mp.md
PSEUDO_COLOR_MP -- requirements
Module: pseudo_color_mp

Interface
REQ-001 Parameter PIXEL_DATA_W, 8, gray pixel width.
REQ-002 Parameter DETAIL_LUT_W, 3, detail bits appended below the gray pixel.
REQ-003 Parameter Y_DATA_W / U_DATA_W / V_DATA_W, 8 / 8 / 8, output component widths; Y_DATA_W >= PIXEL_DATA_W.
REQ-004 Parameter PAL_SEL_W, 2, palette index width (2^PAL_SEL_W palettes).
REQ-005 Derived DATA_LUT_W = PIXEL_DATA_W+DETAIL_LUT_W; YUV_DATA_W = Y+U+V widths; RAM depth 2^(PAL_SEL_W+DATA_LUT_W).
REQ-006 clk_i  input  1  single clock; all logic on its rising edge.
REQ-007 rst_i  input  1  reset, asynchronous assert, active-low.
REQ-008 vsync_i  input  1  frame sync; the rising edge is the palette-switch point.
REQ-009 data_valid_i  input  1  pixel qualifier.
REQ-010 data_lut_i  input  DATA_LUT_W  gray+detail lookup index.
REQ-011 palette_sel_i  input  PAL_SEL_W  requested palette.
REQ-012 bypass_i  input  1  requested grayscale-bypass mode.
REQ-013 cfg_we_i  input  1  palette RAM write strobe.
REQ-014 cfg_addr_i  input  PAL_SEL_W+DATA_LUT_W  write address {palette, index}.
REQ-015 cfg_data_i  input  YUV_DATA_W  write data {Y,U,V}, Y in MSBs.
REQ-016 data_valid_o  output  1  output qualifier.
REQ-017 y_data_o / u_data_o / v_data_o  output  Y/U/V_DATA_W  output pixel components.
REQ-018 palette_act_o  output  PAL_SEL_W  palette currently in use.
REQ-019 cfg_collision_o  output  1  sticky flag: a write hit the active palette while pixels flowed.

Function
REQ-020 Shadow registers pal_act and byp_act load palette_sel_i and bypass_i only on a cycle where vsync_i=1 and the registered vsync_d=0; at all other times they hold.
REQ-021 A pixel accepted in the same cycle as the vsync edge uses the old pal_act/byp_act; pixels from the next cycle use the new values.
REQ-022 Stage 1: when data_valid_i=1, read RAM at {pal_act, data_lut_i}; register valid, byp_act, and data_lut_i[DATA_LUT_W-1 -: PIXEL_DATA_W] alongside the read.
REQ-023 Stage 2: register outputs from the stage-1 values; fixed latency is 2 cycles from data_valid_i to data_valid_o, with no stalls and no back-pressure.
REQ-024 Palette mode: {y,u,v}_data_o = RAM word split as Y = MSBs, U = middle bits, V = LSBs.
REQ-025 Bypass mode: y_data_o = gray pixel MSB-aligned, with zero-padded LSBs; u_data_o = 1<<(U_DATA_W-1); v_data_o = 1<<(V_DATA_W-1).
REQ-026 When data_valid_i=0, stage registers hold their data; only the valid bits propagate 0.
REQ-027 The RAM is simple dual-port (1 write, 1 read) and is inferable as block RAM; it is not reset, and its contents survive rst_i.
REQ-028 Simultaneous write and read of the same address is read-first: the pixel gets the old word, and the next read gets the new word.
REQ-029 cfg_collision_o sets when cfg_we_i=1, data_valid_i=1 and cfg_addr_i palette field == pal_act.
REQ-030 cfg_collision_o clears on the vsync edge (REQ-020); if set and clear occur in the same cycle, set wins.
REQ-031 palette_act_o = pal_act.

Reset
REQ-032 While rst_i=0, the following are all 0: data_valid_o, y/u/v_data_o, pal_act, byp_act, cfg_collision_o, and internal valid bits.
REQ-033 While rst_i=0, vsync_d resets to 1, so a vsync_i already high at reset release causes no switch.
REQ-034 Reset asserted mid-frame discards in-flight pixels, with no spurious data_valid_o after release.
REQ-035 RAM writes issued during reset are ignored.

Verification
REQ-036 Write palette 1, index 0x155 = 0x8040C0; vsync edge with palette_sel_i=1; pixel 0x155 -> two cycles later data_valid_o=1, Y=0x80, U=0x40, V=0xC0.
REQ-037 Change palette_sel_i 1->2 mid-frame with no vsync edge -> palette_act_o stays 1 and outputs still come from palette 1.
REQ-038 bypass_i=1 at a vsync edge; pixel index 0x7F8 (gray 0xFF) -> Y=0xFF, U=0x80, V=0x80.
REQ-039 Same-cycle write 0x112233 and pixel read at active address 0x010 that previously held 0xAABBCC -> output 0xAABBCC, cfg_collision_o=1; next read -> 0x112233; next vsync edge -> cfg_collision_o=0.
REQ-040 Continuous data_valid_i for 16 cycles with rst_i pulsed low at cycle 5 -> outputs 0 immediately; after release, the first data_valid_o arrives exactly 2 cycles after the first new valid.
REQ-041 vsync_i held high through reset release -> palette_act_o stays 0 until vsync_i falls and rises again.
